// File: rtl/shifter_iter.sv
// Iterative barrel shifter: resolves K count bits per cycle, valid/ready on both sides.
// Optional SHIFTER_ITER_ZERO_BYPASS_EN: a zero count skips the BUSY stages.
module shifter_iter #(
  parameter int N = 16,
  parameter int C = 4,
  parameter int K = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] In,
  input  logic [C-1:0] Cnt,
  input  logic [1:0]   Op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Out
);

  localparam int L  = C / K;
  localparam int IW = (L > 1) ? $clog2(L) : 1;
  localparam int RW = $clog2(N);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state, state_nxt;
  logic [IW-1:0]  idx;
  logic [N-1:0]   data;
  logic [C-1:0]   cnt_r;
  logic [1:0]     op_r;
  logic [N-1:0]   out_r;
  logic [K-1:0]   digit;
  logic [C-1:0]   stage_amt;
  logic [N-1:0]   stage_res;
  logic           last_stage;
  logic           accept;

  // Amounts of N or more saturate; rotation wraps mod N.
  function automatic logic [N-1:0] shift_by(input logic [N-1:0] d,
                                            input logic [C-1:0] amt,
                                            input logic [1:0]   op);
    logic [2*N-1:0] dbl;
    logic [RW-1:0]  r;
    logic           big;
    logic [N-1:0]   res;
    big = (32'(amt) >= N);
    r   = RW'(32'(amt) % N);
    dbl = {d, d} << r;
    unique case (op)
      2'b00:   res = dbl[2*N-1:N];
      2'b01:   res = big ? '0 : (d << amt);
      2'b10:   res = big ? {N{d[N-1]}} : $unsigned($signed(d) >>> amt);
      default: res = big ? '0 : (d >> amt);
    endcase
    return res;
  endfunction

  assign accept     = (state == IDLE) && in_valid;
  assign last_stage = (idx == IW'(L - 1));
  assign digit      = cnt_r[int'(idx)*K +: K];

  always_comb begin
    stage_amt = C'(digit) << (int'(idx) * K);
    stage_res = shift_by(data, stage_amt, op_r);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
`ifdef SHIFTER_ITER_ZERO_BYPASS_EN
          state_nxt = (Cnt == '0) ? DONE : BUSY;
`else
          state_nxt = BUSY;
`endif
        end
      end
      BUSY:    if (last_stage) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Stage index and result register are visible state, so they are reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      out_r <= '0;
    end else begin
      if (accept)              idx <= '0;
      else if (state == BUSY)  idx <= idx + IW'(1);
      if (state == BUSY && last_stage) out_r <= stage_res;
`ifdef SHIFTER_ITER_ZERO_BYPASS_EN
      else if (accept && Cnt == '0)    out_r <= In;
`endif
    end
  end

  // Working operand and latched request; don't-care until the next accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      data  <= In;
      cnt_r <= Cnt;
      op_r  <= Op;
    end else if (state == BUSY) begin
      data  <= stage_res;
    end
  end

  assign Out = out_r;

endmodule
